// File: rtl/vc_pop_arbiter.sv
// Reader side of the two virtual-channel FIFOs: priority arbitration with anti-starvation,
// combinational pop strobes and a registered one-word output stage for the downstream FIFO.
module vc_pop_arbiter #(
  parameter int BW     = 6,
  parameter int WEIGHT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          vc0_empty,
  input  logic [BW-1:0] vc0_data,
  input  logic          vc1_empty,
  input  logic [BW-1:0] vc1_data,
  input  logic          fifo_error,
  input  logic          dest_almost_full,
  output logic          vc0_rd,
  output logic          vc1_rd,
  output logic [BW-1:0] data_out,
  output logic          valid_out,
  output logic          vc_out,
  output logic [1:0]    state,
  output logic          error_out,
  output logic [7:0]    pop_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(WEIGHT);

  logic [1:0] state_next;
  logic [3:0] streak;
  logic       allowed;
  logic       force0;
  logic       pop;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN: begin
        if (!enable)               state_next = IDLE;
        else if (dest_almost_full) state_next = STALL;
      end
      STALL: begin
        if (!enable)                state_next = IDLE;
        else if (!dest_almost_full) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // almost_full gates the strobes in the same cycle it rises, not only via the STALL state.
  assign allowed = (state == RUN) && !dest_almost_full;
  assign force0  = (streak == STREAK_MAX) && !vc0_empty;
  assign vc1_rd  = allowed && !vc1_empty && !force0;
  assign vc0_rd  = allowed && !vc0_empty && !vc1_rd;
  assign pop     = vc0_rd | vc1_rd;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the output stage is a handful of flops, so it is reset along with the control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      vc_out    <= 1'b0;
    end else begin
      valid_out <= pop;
      if (pop) begin
        data_out <= vc1_rd ? vc1_data : vc0_data;
        vc_out   <= vc1_rd;
      end
    end
  end

  // Streak counts VC1 wins while VC0 is waiting; any VC0 pop or an empty VC0 restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (vc0_empty || vc0_rd) begin
      streak <= '0;
    end else if (vc1_rd && streak != STREAK_MAX) begin
      streak <= streak + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_count <= '0;
      error_out <= 1'b0;
    end else begin
      if (pop)        pop_count <= pop_count + 8'd1;
      if (fifo_error) error_out <= 1'b1;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(vc0_rd && vc1_rd));

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter: queue-based VC FIFO models, expected-word scoreboard
// filled by the stimulus and drained by an independent negedge monitor.
module tb_vc_pop_arbiter;

  localparam int BW = 6;

  typedef struct packed {
    logic          vc;
    logic [BW-1:0] data;
  } exp_t;

  // Hand-computed pop order for WEIGHT=4, VC1 = 0x20..0x29, VC0 = 0x30..0x39 ({vc, data}).
  localparam logic [6:0] ORDER2 [20] = '{
    7'h60, 7'h61, 7'h62, 7'h63, 7'h30,
    7'h64, 7'h65, 7'h66, 7'h67, 7'h31,
    7'h68, 7'h69, 7'h32, 7'h33, 7'h34,
    7'h35, 7'h36, 7'h37, 7'h38, 7'h39
  };

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          vc0_empty;
  logic [BW-1:0] vc0_data;
  logic          vc1_empty;
  logic [BW-1:0] vc1_data;
  logic          fifo_error;
  logic          dest_almost_full;
  logic          vc0_rd;
  logic          vc1_rd;
  logic [BW-1:0] data_out;
  logic          valid_out;
  logic          vc_out;
  logic [1:0]    state;
  logic          error_out;
  logic [7:0]    pop_count;

  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  exp_t          exp_q[$];

  logic rd0_s = 1'b0;
  logic rd1_s = 1'b0;
  logic prev_pop = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  vc_pop_arbiter #(.BW(BW), .WEIGHT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .vc0_empty        (vc0_empty),
    .vc0_data         (vc0_data),
    .vc1_empty        (vc1_empty),
    .vc1_data         (vc1_data),
    .fifo_error       (fifo_error),
    .dest_almost_full (dest_almost_full),
    .vc0_rd           (vc0_rd),
    .vc1_rd           (vc1_rd),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .vc_out           (vc_out),
    .state            (state),
    .error_out        (error_out),
    .pop_count        (pop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    vc0_data  = vc0_empty ? '0 : q0[0];
    vc1_data  = vc1_empty ? '0 : q1[0];
  endtask

  // Advance one cycle; the FIFO models pop on the edge where the DUT strobe was high.
  task automatic tick();
    logic [BW-1:0] d;
    @(posedge clk);
    #1;
    if (rd0_s && q0.size() > 0) d = q0.pop_front();
    if (rd1_s && q1.size() > 0) d = q1.pop_front();
    refresh();
    #1;
  endtask

  task automatic load(input logic vc, input logic [BW-1:0] d, input logic expect_it);
    if (vc) q1.push_back(d);
    else    q0.push_back(d);
    if (expect_it) exp_q.push_back('{vc: vc, data: d});
    refresh();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q0.size() + q1.size() + exp_q.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_scoreboard", exp_q.size(), 0);
  endtask

  // Monitor: checks strobe legality, 1-cycle latency and every presented word.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_pop = 1'b0;
      rd0_s    = 1'b0;
      rd1_s    = 1'b0;
    end else begin
      check("strobe_exclusive", {31'd0, vc0_rd & vc1_rd}, 0);
      if (vc0_rd) check("rd0_nonempty", {31'd0, vc0_empty}, 0);
      if (vc1_rd) check("rd1_nonempty", {31'd0, vc1_empty}, 0);
      check("valid_latency", {31'd0, valid_out}, {31'd0, prev_pop});
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'd0, valid_out}, 0);
        end else begin
          e = exp_q.pop_front();
          check("data_out", {26'd0, data_out}, {26'd0, e.data});
          check("vc_out", {31'd0, vc_out}, {31'd0, e.vc});
        end
      end
      prev_pop = vc0_rd | vc1_rd;
      rd0_s    = vc0_rd;
      rd1_s    = vc1_rd;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rd;
    int n_val;
    reset = 1'b1; enable = 1'b0; fifo_error = 1'b0; dest_almost_full = 1'b0;
    refresh();
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_data", data_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_vc", vc_out, 0);
    check("rst_error", error_out, 0);
    check("rst_count", pop_count, 0);
    reset = 1'b0;
    tick();

    // VC1 only: three words, one cycle of IDLE->RUN before the first strobe.
    load(1'b1, 6'h11, 1'b1); load(1'b1, 6'h12, 1'b1); load(1'b1, 6'h13, 1'b1);
    enable = 1'b1;
    n_rd = 0; n_val = 0;
    repeat (8) begin
      tick();
      n_rd  += int'(vc1_rd);
      n_val += int'(valid_out);
    end
    check("t1_vc1_rd_cycles", n_rd, 3);
    check("t1_valid_cycles", n_val, 3);
    check("t1_state_run", state, 1);
    check("t1_pop_count", pop_count, 3);

    // Both VCs loaded: anti-starvation ordering.
    for (int i = 0; i < 10; i++) begin
      load(1'b1, 6'(6'h20 + i), 1'b0);
      load(1'b0, 6'(6'h30 + i), 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      logic [6:0] o;
      o = ORDER2[i];
      exp_q.push_back('{vc: o[6], data: o[5:0]});
    end
    wait_drain(100);
    check("t2_pop_count", pop_count, 23);

    // almost_full throttling mid-stream.
    for (int i = 1; i <= 8; i++) load(1'b1, 6'(i), 1'b1);
    tick();
    tick();
    dest_almost_full = 1'b1;
    #1;
    check("t3_no_strobe_on_rise", {31'd0, vc0_rd | vc1_rd}, 0);
    check("t3_inflight_valid", valid_out, 1);
    check("t3_state_still_run", state, 1);
    tick();
    check("t3_state_stall", state, 2);
    check("t3_valid_drops", valid_out, 0);
    n_rd = 0;
    repeat (3) begin
      tick();
      n_rd += int'(vc0_rd | vc1_rd);
    end
    check("t3_stall_strobes", n_rd, 0);
    check("t3_stall_hold", state, 2);
    dest_almost_full = 1'b0;
    tick();
    check("t3_resume_state", state, 1);
    check("t3_resume_pop", vc1_rd, 1);
    wait_drain(100);
    check("t3_pop_count", pop_count, 31);

    // Both FIFOs empty while running.
    n_rd = 0; n_val = 0;
    repeat (20) begin
      tick();
      n_rd  += int'(vc0_rd | vc1_rd);
      n_val += int'(valid_out);
    end
    check("t4_idle_strobes", n_rd, 0);
    check("t4_idle_valid", n_val, 0);
    check("t4_state_run", state, 1);

    // Sticky error, then asynchronous reset mid-stream.
    fifo_error = 1'b1;
    tick();
    fifo_error = 1'b0;
    check("t5_error_set", error_out, 1);
    repeat (3) tick();
    check("t5_error_sticky", error_out, 1);
    load(1'b1, 6'h0A, 1'b1);
    load(1'b1, 6'h0B, 1'b0);
    load(1'b1, 6'h0C, 1'b0);
    load(1'b1, 6'h0D, 1'b0);
    tick();
    tick();
    check("t5_pre_data", data_out, 6'h0B);
    check("t5_pre_count", pop_count, 33);
    #1 reset = 1'b1;
    #1;
    check("t5_async_state", state, 0);
    check("t5_async_data", data_out, 0);
    check("t5_async_valid", valid_out, 0);
    check("t5_async_vc", vc_out, 0);
    check("t5_async_error", error_out, 0);
    check("t5_async_count", pop_count, 0);
    q1.delete();
    refresh();
    tick(); tick();
    reset = 1'b0;

    // 260 pops: pop_count wraps to 4.
    for (int i = 0; i < 260; i++) load(1'b1, 6'(i), 1'b1);
    wait_drain(400);
    check("t6_count_wrap", pop_count, 4);

    // enable dropped mid-burst: the last captured word still appears.
    for (int i = 0; i < 6; i++) load(1'b0, 6'(6'h15 + i), (i < 3));
    tick();
    tick();
    enable = 1'b0;
    #1;
    check("t7_last_run_pop", vc0_rd, 1);
    tick();
    check("t7_state_idle", state, 0);
    check("t7_no_strobe", {31'd0, vc0_rd | vc1_rd}, 0);
    check("t7_last_valid", valid_out, 1);
    check("t7_last_data", data_out, 6'h17);
    n_rd = 0;
    repeat (5) begin
      tick();
      n_rd += int'(vc0_rd | vc1_rd);
    end
    check("t7_idle_strobes", n_rd, 0);
    check("t7_pop_count", pop_count, 7);
    check("t7_scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
